// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional build macro ID_EX_PERF_EN adds a saturating load-use bubble counter.
module id_ex_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic                  id_valid,
    input  logic [1:0]            id_jump,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_alu_op,
    input  logic [2:0]            id_funct3,
    input  logic [6:0]            id_funct7,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic [1:0]            ex_jump,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use_stall,
    output logic [31:0]           bubble_count
);

    logic use_rs1;
    logic use_rs2;
    logic hazard;

    // JAL reads no registers; only non-jump R-type, branches and stores read rs2.
    assign use_rs1 = (id_jump != 2'b01);
    assign use_rs2 = (id_jump == 2'b00) && (!id_alu_src || id_mem_write);

    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                    && ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)))
                    && !flush;

    assign load_use_stall = hazard;

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall_in && hazard)) begin
            ex_valid      <= 1'b0;
            ex_jump       <= '0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= '0;
            ex_funct3     <= '0;
            ex_funct7     <= '0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
        end else if (!stall_in) begin
            ex_valid      <= id_valid;
            ex_jump       <= id_jump;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_reg_write  <= id_reg_write;
            ex_alu_op     <= id_alu_op;
            ex_funct3     <= id_funct3;
            ex_funct7     <= id_funct7;
            ex_pc         <= id_pc;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt;

    // hazard already excludes flush; stall_in suppresses the bubble load.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (hazard && !stall_in && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign bubble_count = bubble_cnt;
`else
    assign bubble_count = 32'h0;
`endif

endmodule
